// File: rtl/usuario_panel.sv
// usuario_panel: push-button edge detection, saturating 4-bit selection and
// an active-low LED display that is latched on each start press.
`default_nettype none

module usuario_panel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       start_i,
  output logic [3:0] leds
);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       inc_q, dec_q, start_q;
  logic [3:0] sel_q, sel_d;
  logic [3:0] shown_q, shown_d;
  logic [3:0] leds_q, leds_d;
  logic       inc_ev, dec_ev, start_ev;

  assign inc_ev   = inc_i & ~inc_q;
  assign dec_ev   = dec_i & ~dec_q;
  assign start_ev = start_i & ~start_q;

  always_comb begin
    sel_d = sel_q;
    if (inc_ev && !dec_ev && sel_q != 4'hF)
      sel_d = sel_q + 4'd1;
    else if (dec_ev && !inc_ev && sel_q != 4'h0)
      sel_d = sel_q - 4'd1;
  end

  // A start in the same cycle as inc/dec captures the pre-update selection.
  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    if (start_ev) begin
      state_d = SHOW;
      shown_d = sel_q;
    end
    leds_d = (state_d == SHOW) ? ~shown_d : 4'b1111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      start_q <= 1'b0;
      sel_q   <= 4'h0;
      shown_q <= 4'h0;
      leds_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_i;
      dec_q   <= dec_i;
      start_q <= start_i;
      sel_q   <= sel_d;
      shown_q <= shown_d;
      leds_q  <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_usuario_panel.sv
// Self-checking bench for usuario_panel: a behavioural model pushes expected
// LED values into a scoreboard queue, which is popped when the DUT is sampled.
`default_nettype none

module tb_usuario_panel;

  logic       clk;
  logic       rst_n;
  logic       inc_i, dec_i, start_i;
  logic [3:0] leds;

  usuario_panel dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inc_i),
    .dec_i   (dec_i),
    .start_i (start_i),
    .leds    (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];

  // Reference model state
  logic [3:0] m_sel, m_shown;
  logic       m_show;
  logic       p_inc, p_dec, p_start;

  function automatic logic [3:0] m_leds();
    return m_show ? ~m_shown : 4'b1111;
  endfunction

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: leds=%b expected=%b", tag, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back(m_leds());
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty, leds=%b expected=none", tag, leds);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, leds, e);
    end
  endtask

  task automatic model_reset();
    m_sel = 4'h0; m_shown = 4'h0; m_show = 1'b0;
    p_inc = 1'b0; p_dec = 1'b0; p_start = 1'b0;
  endtask

  // One rising edge: model evaluates events against its own previous levels.
  task automatic step();
    logic ie, de, se;
    @(posedge clk);
    ie = inc_i & ~p_inc;
    de = dec_i & ~p_dec;
    se = start_i & ~p_start;
    if (se) begin
      m_show  = 1'b1;
      m_shown = m_sel;
    end
    if (ie && !de && m_sel != 4'hF) m_sel = m_sel + 4'd1;
    else if (de && !ie && m_sel != 4'h0) m_sel = m_sel - 4'd1;
    p_inc = inc_i; p_dec = dec_i; p_start = start_i;
    #1;
  endtask

  task automatic press(input logic i, input logic d, input logic s);
    @(negedge clk);
    inc_i = i; dec_i = d; start_i = s;
    step();
    @(negedge clk);
    inc_i = 1'b0; dec_i = 1'b0; start_i = 1'b0;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    push_exp();
    pop_check("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; inc_i = 1'b0; dec_i = 1'b0; start_i = 1'b0;
    model_reset();

    // Idle after reset
    do_reset();
    repeat (5) step();
    push_exp(); pop_check("idle_5");

    // inc once, start, then start held
    do_reset();
    press(1, 0, 0);
    @(negedge clk); start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k > 0) begin
        push_exp(); pop_check("start_held");
      end
    end
    @(negedge clk); start_i = 1'b0;
    step();
    push_exp(); pop_check("start_released");

    // 5 inc, 2 dec, start -> sel 3
    do_reset();
    repeat (5) press(1, 0, 0);
    repeat (2) press(0, 1, 0);
    press(0, 0, 1);
    push_exp(); pop_check("inc5_dec2");

    // Saturation at both ends
    do_reset();
    press(0, 1, 0);
    press(0, 0, 1);
    push_exp(); pop_check("sat_low");
    repeat (20) press(1, 0, 0);
    push_exp(); pop_check("inc_no_leds_change");
    press(0, 0, 1);
    push_exp(); pop_check("sat_high");

    // SHOW behaviour with sel = 1
    do_reset();
    press(1, 0, 0);
    press(0, 0, 1);
    push_exp(); pop_check("show_sel1");
    press(1, 0, 0);
    push_exp(); pop_check("inc_in_show");
    press(0, 0, 1);
    push_exp(); pop_check("reshow_sel2");
    press(1, 1, 0);
    press(0, 0, 1);
    push_exp(); pop_check("inc_dec_same");
    press(1, 0, 1);
    push_exp(); pop_check("start_with_inc");
    press(0, 0, 1);
    push_exp(); pop_check("after_start_with_inc");

    // Async reset between edges while in SHOW
    do_reset();
    press(1, 0, 0);
    press(0, 0, 1);
    push_exp(); pop_check("pre_reset_show");
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_exp(); pop_check("mid_reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) step();
    push_exp(); pop_check("post_reset_idle");

    // Button held through reset release counts as a press
    @(negedge clk);
    rst_n = 1'b0; inc_i = 1'b1;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step();
    @(negedge clk); inc_i = 1'b0;
    step();
    press(0, 0, 1);
    push_exp(); pop_check("held_through_reset");

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: entries=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim_time=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
